// File: rtl/i2s_capture_mc.sv
// i2s_capture_mc: I2S master receiver, decimating, byte-stream output.
// Define I2S_CAPTURE_TEST_PATTERN_EN to replace samples with a counter.
module i2s_capture_mc #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int I2S_CLK_FREQ = 1_500_000,
  parameter int DATA_SIZE    = 24,
  parameter int SLOT_SIZE    = 32,
  parameter int CHANNELS     = 2,
  parameter int OUT_BYTES    = 2,
  parameter int DECIMATE     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        i2s_clk,
  output logic        i2s_ws,
  input  logic        i2s_sd,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        overrun,
  output logic [15:0] drop_count
);
  localparam int HD_RAW   = CLK_FREQ / (2 * I2S_CLK_FREQ);
  localparam int HALF_DIV = (HD_RAW < 1) ? 1 : HD_RAW;
  localparam int DW       = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int FRAME    = 2 * SLOT_SIZE;
  localparam int PW       = $clog2(FRAME);
  localparam int OW       = OUT_BYTES * 8;
  localparam int IW       = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
  localparam int FW       = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
  localparam bit STEREO   = (CHANNELS == 2);
  localparam bit FULLW    = (OW == DATA_SIZE);

  localparam logic [DW-1:0] DIV_MAX = DW'(HALF_DIV - 1);
  localparam logic [PW-1:0] P_MAX   = PW'(FRAME - 1);
  localparam logic [PW-1:0] P_SLOT  = PW'(SLOT_SIZE);
  localparam logic [PW-1:0] L_HI    = PW'(OW);
  localparam logic [PW-1:0] R_LO    = PW'(SLOT_SIZE + 1);
  localparam logic [PW-1:0] R_HI    = PW'(SLOT_SIZE + OW);
  localparam logic [PW-1:0] L_END   = PW'(DATA_SIZE);
  localparam logic [PW-1:0] R_END   = PW'(SLOT_SIZE + DATA_SIZE);
  localparam logic [IW-1:0] I_MAX   = IW'(OUT_BYTES - 1);
  localparam logic [FW-1:0] F_MAX   = FW'(DECIMATE - 1);

  logic [DW-1:0] div_cnt;
  logic [PW-1:0] p, p_nxt;
  logic [FW-1:0] frm;
  logic [OW-1:0] shreg, word, obuf;
  logic [IW-1:0] idx;
  logic          tick, rise_stb, fall_stb;
  logic          cap, done, xfer, last, load, drop;

  // Only the kept top OW bits are shifted; later data bits are truncated.
  always_comb begin
    tick     = enable && (div_cnt == DIV_MAX);
    rise_stb = tick && !i2s_clk;
    fall_stb = tick && i2s_clk;
    p_nxt    = (p == P_MAX) ? '0 : p + 1'b1;
    cap      = rise_stb &&
               (((p != '0) && (p <= L_HI)) ||
                (STEREO && (p >= R_LO) && (p <= R_HI)));
    done     = rise_stb && (frm == '0) &&
               ((p == L_END) || (STEREO && (p == R_END)));
    xfer     = byte_valid && byte_ready;
    last     = (idx == I_MAX);
    load     = done && (!byte_valid || (xfer && last));
    drop     = done && !load;
  end

`ifdef I2S_CAPTURE_TEST_PATTERN_EN
  logic [DATA_SIZE-1:0] pat;

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) pat <= '0;
    else if (done)         pat <= pat + 1'b1;
  end

  assign word = pat[DATA_SIZE-1 -: OW];
`else
  assign word = FULLW ? {shreg[OW-2:0], i2s_sd} : shreg;
`endif

  assign byte_out = obuf[OW-1 -: 8];

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      div_cnt    <= '0;
      i2s_clk    <= 1'b0;
      i2s_ws     <= 1'b0;
      p          <= '0;
      frm        <= '0;
      shreg      <= '0;
      obuf       <= '0;
      idx        <= '0;
      byte_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= drop;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) i2s_clk <= !i2s_clk;
      if (fall_stb) begin
        p      <= p_nxt;
        i2s_ws <= (p_nxt >= P_SLOT);
        if (p == P_MAX) frm <= (frm == F_MAX) ? '0 : frm + 1'b1;
      end
      if (cap) shreg <= {shreg[OW-2:0], i2s_sd};
      if (load) begin
        obuf       <= word;
        idx        <= '0;
        byte_valid <= 1'b1;
      end else if (xfer) begin
        obuf <= obuf << 8;
        idx  <= idx + 1'b1;
        if (last) byte_valid <= 1'b0;
      end
    end
  end

  // Drop count survives enable low; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n)
      drop_count <= '0;
    else if (drop && (drop_count != 16'hFFFF))
      drop_count <= drop_count + 1'b1;
  end
endmodule

// File: tb/tb_i2s_capture_mc.sv
// tb_i2s_capture_mc: directed checks of i2s_capture_mc.
// Stereo default instance plus a mono, decimate-by-4, 3-byte instance.
`timescale 1ns/1ps
module tb_i2s_capture_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable, en2, byte_ready, ready2;
  logic        i2s_sd, m_sd;
  logic        i2s_clk, i2s_ws, byte_valid, overrun;
  logic [7:0]  byte_out;
  logic [15:0] drop_count;
  logic        m_clk, m_ws, m_valid, m_overrun;
  logic [7:0]  m_byte;
  logic [15:0] m_drops;
  logic [23:0] left, right;

  int vecs = 0;
  int errs = 0;

  i2s_capture_mc u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .i2s_clk(i2s_clk), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
    .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .overrun(overrun),
    .drop_count(drop_count)
  );

  i2s_capture_mc #(.CHANNELS(1), .OUT_BYTES(3), .DECIMATE(4)) u_mono (
    .clk(clk), .rst_n(rst_n), .enable(en2),
    .i2s_clk(m_clk), .i2s_ws(m_ws), .i2s_sd(m_sd),
    .byte_out(m_byte), .byte_valid(m_valid),
    .byte_ready(ready2), .overrun(m_overrun),
    .drop_count(m_drops)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Standard I2S mic: MSB one bit clock after the ws edge.
  function automatic logic mic_bit(int k, logic [23:0] l, logic [23:0] r);
    if (k >= 1 && k <= 24) return l[24-k];
    if (k >= 33 && k <= 56) return r[56-k];
    return 1'b0;
  endfunction

  int k = 0, k2 = 0, f2 = 0;
  logic pc = 1'b0, pc2 = 1'b0;

  always @(negedge clk) begin
    if (!rst_n || !enable) begin
      k = 0; pc = 1'b0;
    end else begin
      if (pc && !i2s_clk) k = (k + 1) % 64;
      pc = i2s_clk;
    end
    i2s_sd = mic_bit(k, left, right);
  end

  always @(negedge clk) begin
    if (!rst_n || !en2) begin
      k2 = 0; f2 = 0; pc2 = 1'b0;
    end else begin
      if (pc2 && !m_clk) begin
        k2 = (k2 + 1) % 64;
        if (k2 == 0) f2++;
      end
      pc2 = m_clk;
    end
    m_sd = mic_bit(k2, {8'(f2), 16'hA55A}, 24'hFFFFFF);
  end

  // Stream / edge monitor, stamped in cycles since reset release.
  int cyc = 0;
  logic [7:0] q[$], q2[$];
  int qt[$], clk_rise[$];
  int ws_rise = -1, ws_fall = -1, ovr = 0, ovr2 = 0, ws2n = 0, hold_bad = 0;
  logic p_clk = 0, p_ws = 0, p_v = 0, p_r = 0, p_ws2 = 0;
  logic [7:0] p_b = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0;
    end else begin
      if (byte_valid && byte_ready) begin
        q.push_back(byte_out); qt.push_back(cyc);
      end
      if (m_valid && ready2) q2.push_back(m_byte);
      if (i2s_clk && !p_clk) clk_rise.push_back(cyc);
      if (i2s_ws && !p_ws && ws_rise < 0) ws_rise = cyc;
      if (!i2s_ws && p_ws && ws_fall < 0) ws_fall = cyc;
      if (m_ws != p_ws2) ws2n++;
      if (overrun) ovr++;
      if (m_overrun) ovr2++;
      if (enable && p_v && !p_r && (!byte_valid || byte_out != p_b))
        hold_bad++;
      cyc++;
    end
    p_clk = i2s_clk; p_ws = i2s_ws; p_ws2 = m_ws;
    p_v = byte_valid; p_r = byte_ready; p_b = byte_out;
  end

  function automatic logic [31:0] qb(int i);
    return (i < q.size()) ? 32'(q[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] qs(int i);
    return (i < qt.size()) ? 32'(qt[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] q2b(int i);
    return (i < q2.size()) ? 32'(q2[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] cr(int i);
    return (i < clk_rise.size()) ? 32'(clk_rise[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic wait_until(input int n);
    while (cyc < n) @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_st[4] = '{8'hA5, 8'hC3, 8'h12, 8'h34};
  logic [7:0] exp_re[4] = '{8'h0F, 8'h1E, 8'h3C, 8'h4B};
  logic [7:0] exp_mo[6] = '{8'h00, 8'hA5, 8'h5A, 8'h04, 8'hA5, 8'h5A};

  initial begin
    rst_n = 0; enable = 1; en2 = 1; byte_ready = 1; ready2 = 1;
    left = 24'hA5C3F1; right = 24'h123456;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_i2s_clk", i2s_clk, 0);
    end
    check("rst_ws", i2s_ws, 0);
    check("rst_byte_out", byte_out, 0);
    check("rst_valid", byte_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_drops", drop_count, 0);
    rst_n = 1;

    // stereo capture, clock and ws timing
    wait_until(1900);
    check("first_rise", cr(0), 16);
    check("second_rise", cr(1), 48);
    check("ws_rise", ws_rise, 1024);
    check("st_count", q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("st_byte%0d", i), qb(i), exp_st[i]);
    check("st_t0", qs(0), 784);
    check("st_t1", qs(1), 785);
    check("st_t2", qs(2), 1808);

    // stall one frame: left held, right dropped
    left = 24'h5A3C99; right = 24'h778899; byte_ready = 0;
    q.delete(); qt.delete();
    wait_until(4000);
    check("ws_fall", ws_fall, 2048);
    check("ovr_pulses", ovr, 1);
    check("ovr_drops", drop_count, 1);
    check("ovr_none_out", q.size(), 0);
    byte_ready = 1;
    wait_until(4790);
    check("ovr_count", q.size(), 2);
    check("ovr_b0", qb(0), 8'h5A);
    check("ovr_b1", qb(1), 8'h3C);
    check("hold", hold_bad, 0);
    byte_ready = 0;

    // enable drop at p=10 with a held byte
    wait_until(6485);
    check("pre_clk", i2s_clk, 1);
    check("pre_valid", byte_valid, 1);
    check("pre_byte", byte_out, 8'h5A);
    enable = 0;
    left = 24'h0F1E2D; right = 24'h3C4B5A;
    @(posedge clk); #1;
    check("flush_clk", i2s_clk, 0);
    check("flush_ws", i2s_ws, 0);
    check("flush_valid", byte_valid, 0);
    check("flush_drops", drop_count, 2);
    check("flush_ovr", ovr, 2);
    q.delete(); qt.delete();
    byte_ready = 1;
    wait_until(6600);
    enable = 1;
    wait_until(8500);
    check("re_count", q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("re_byte%0d", i), qb(i), exp_re[i]);
    check("re_t0", qs(0), 7384);
    check("re_t2", qs(2), 8408);

    // mono decimate-by-4 instance over 8 frames
    wait_until(16500);
    check("mono_count", q2.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("mono_byte%0d", i), q2b(i), exp_mo[i]);
    check("mono_ws_edges", ws2n, 16);
    check("mono_ovr", ovr2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
